// File: rtl/svid_frame_loader_pkg.sv
// Shared definitions for the SVID frame loader: FSM states, frame geometry and
// a helper that drops one 32-bit word into a 256-bit signature/hash vector.
package svid_frame_loader_pkg;

   localparam int FRAME_WORDS = 16;
   localparam int SIG_WORDS   = 8;
   localparam int WORD_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_WAIT,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Slot 0 is the most significant word of the vector.
   function automatic logic [SIG_WORDS*WORD_W-1:0] insert_word(
      input logic [SIG_WORDS*WORD_W-1:0] vec,
      input logic [2:0]                  slot,
      input logic [WORD_W-1:0]           word
   );
      logic [SIG_WORDS*WORD_W-1:0] res;
      res = vec;
      res[(SIG_WORDS-1-int'(slot))*WORD_W +: WORD_W] = word;
      return res;
   endfunction

endpackage

// File: rtl/svid_frame_loader.sv
// Collects a 16-word frame (8 signature + 8 hash words), starts the external
// verifier, waits a fixed latency for its verdict and reports it on a handshake.
module svid_frame_loader
   import svid_frame_loader_pkg::*;
#(
   parameter int MATCH_LATENCY = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  s_data,
   input  logic         s_valid,
   input  logic         s_last,
   output logic         s_ready,
   output logic [255:0] signature,
   output logic [255:0] hash,
   output logic         verify_enable,
   input  logic         signature_match,
   output logic         result_valid,
   output logic         result_pass,
   output logic         result_error,
   input  logic         result_ready
);

   localparam logic [3:0] LAT      = 4'(MATCH_LATENCY);
   localparam logic [3:0] LAST_IDX = 4'(FRAME_WORDS - 1);

   state_t       state_q, state_d;
   logic [3:0]   word_cnt_q, word_cnt_d;
   logic [3:0]   lat_cnt_q, lat_cnt_d;
   logic [255:0] sig_q, sig_d;
   logic [255:0] hash_q, hash_d;
   logic         pass_q, pass_d;
   logic         error_q, error_d;
   logic         xfer;

   assign s_ready      = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DRAIN);
   assign xfer         = s_valid && s_ready;
   assign signature    = sig_q;
   assign hash         = hash_q;
   assign result_pass  = pass_q;
   assign result_error = error_q;

   always_comb begin
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      lat_cnt_d     = lat_cnt_q;
      sig_d         = sig_q;
      hash_d        = hash_q;
      pass_d        = pass_q;
      error_d       = error_q;
      verify_enable = 1'b0;
      result_valid  = 1'b0;

      case (state_q)
         // The counter is zero in IDLE, so IDLE and LOAD share the same word path.
         ST_IDLE, ST_LOAD: begin
            if (xfer) begin
               if (word_cnt_q[3]) begin
                  hash_d = insert_word(hash_q, word_cnt_q[2:0], s_data);
               end else begin
                  sig_d = insert_word(sig_q, word_cnt_q[2:0], s_data);
               end
               if (word_cnt_q == LAST_IDX) begin
                  state_d = s_last ? ST_VERIFY : ST_DRAIN;
               end else if (s_last) begin
                  state_d = ST_DONE;
                  pass_d  = 1'b0;
                  error_d = 1'b1;
               end else begin
                  state_d    = ST_LOAD;
                  word_cnt_d = word_cnt_q + 4'd1;
               end
            end
         end
         ST_VERIFY: begin
            verify_enable = 1'b1;
            lat_cnt_d     = 4'd1;
            state_d       = ST_WAIT;
         end
         // lat_cnt_q holds the number of cycles elapsed since the verify pulse.
         ST_WAIT: begin
            if (lat_cnt_q == LAT) begin
               pass_d  = signature_match;
               error_d = 1'b0;
               state_d = ST_DONE;
            end else begin
               lat_cnt_d = lat_cnt_q + 4'd1;
            end
         end
         ST_DRAIN: begin
            if (xfer && s_last) begin
               state_d = ST_DONE;
               pass_d  = 1'b0;
               error_d = 1'b1;
            end
         end
         ST_DONE: begin
            result_valid = 1'b1;
            if (result_ready) begin
               state_d    = ST_IDLE;
               word_cnt_d = 4'd0;
               lat_cnt_d  = 4'd0;
               pass_d     = 1'b0;
               error_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         word_cnt_q <= 4'd0;
         lat_cnt_q  <= 4'd0;
         sig_q      <= '0;
         hash_q     <= '0;
         pass_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
         sig_q      <= sig_d;
         hash_q     <= hash_d;
         pass_q     <= pass_d;
         error_q    <= error_d;
      end
   end

endmodule

// File: doc/svid_frame_loader.md
SVID_FRAME_LOADER -- requirements
Module: svid_frame_loader

Interface
REQ-001 The block SHALL have parameter MATCH_LATENCY, default 1, meaning cycles from verify_enable to a valid signature_match; legal range 1-15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have ports s_data (input, 32), s_valid (input, 1), s_last (input, 1) and s_ready (output, 1), forming the word-stream input.
REQ-005 The block SHALL have port signature, output, 256, the assembled signature to the verifier.
REQ-006 The block SHALL have port hash, output, 256, the assembled hash to the verifier.
REQ-007 The block SHALL have port verify_enable, output, 1, a one-cycle start pulse to the verifier.
REQ-008 The block SHALL have port signature_match, input, 1, the verifier result.
REQ-009 The block SHALL have ports result_valid (output, 1), result_pass (output, 1), result_error (output, 1) and result_ready (input, 1), forming the result handshake.

Function
REQ-010 A word SHALL transfer on a cycle with s_valid && s_ready.
REQ-011 A frame SHALL be exactly 16 words: words 0-7 form signature and words 8-15 form hash, MSB word first (word 0 -> signature[255:224], word 8 -> hash[255:224]).
REQ-012 The FSM SHALL have states IDLE, LOAD, VERIFY, WAIT, DRAIN and DONE.
REQ-013 IDLE SHALL drive s_ready=1, and the first transfer SHALL move the FSM to LOAD with word count 1.
REQ-014 LOAD SHALL drive s_ready=1, with a 4-bit word counter that increments per transfer.
REQ-015 When the transfer of word 15 carries s_last=1, the FSM SHALL go to VERIFY.
REQ-016 When s_last=1 arrives on any word 0-14, the FSM SHALL go to DONE with result_error=1 and result_pass=0, and the verifier SHALL not be started.
REQ-017 When word 15 arrives with s_last=0, the FSM SHALL go to DRAIN.
REQ-018 DRAIN SHALL drive s_ready=1 and discard words; the transfer carrying s_last=1 SHALL move the FSM to DONE with result_error=1.
REQ-019 VERIFY SHALL assert verify_enable for exactly one cycle and then go to WAIT; s_ready SHALL be 0.
REQ-020 WAIT SHALL count MATCH_LATENCY cycles from the verify_enable cycle and then sample signature_match into result_pass, with result_error=0, and go to DONE.
REQ-021 signature and hash SHALL be stable from VERIFY through the end of DONE.
REQ-022 DONE SHALL hold result_valid=1 with result_pass and result_error constant until result_valid && result_ready, then return to IDLE.
REQ-023 s_ready SHALL be 0 in VERIFY, WAIT and DONE.
REQ-024 Back-to-back frames SHALL be supported: the first word of the next frame is accepted in the cycle after the DONE handshake.
REQ-025 result_pass and result_error SHALL never both be 1.
REQ-026 signature_match SHALL be ignored outside the WAIT sample cycle.

Reset
REQ-027 When reset=1 at a rising edge, the FSM SHALL enter IDLE and the word counter and latency counter SHALL clear.
REQ-028 On reset, signature, hash, verify_enable, result_valid, result_pass and result_error SHALL be 0, and s_ready SHALL be 1.
REQ-029 Reset SHALL override any in-progress frame, verify or pending result; the partial frame is discarded and no result is reported.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, FRAME_WORDS=16, SIG_WORDS=8 and WORD_W=32.
REQ-031 The block SHALL instantiate no sub-module; the verifier is instantiated beside it by the parent.

Verification
REQ-032 Bench case, normal pass: 16 words (sig=0xA5 repeated, hash=0x3C repeated), last on word 15, signature_match=1 -> one verify_enable pulse, then with MATCH_LATENCY=1 result_valid=1, result_pass=1, result_error=0, and the signature/hash outputs equal the sent values.
REQ-033 Bench case, fail: same frame with signature_match=0 -> result_pass=0, result_error=0.
REQ-034 Bench case, early last: s_last on word 5 -> result_error=1, verify_enable never asserted.
REQ-035 Bench case, missing last: 20 words with last on word 19 -> 4 words discarded, result_error=1, verify_enable never asserted.
REQ-036 Bench case, backpressure: result_ready=0 for 10 cycles -> result held stable and s_ready=0, then IDLE and the next frame is accepted in the following cycle.
REQ-037 Bench case, reset mid-frame: reset after word 9 -> all outputs at reset values, s_ready=1, no result_valid; a new full frame then passes normally.
